// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 access codes,
// write-back select encoding and the LSU state type.
package dmem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] WB_ALU = 3'd0;
    localparam logic [2:0] WB_PC4 = 3'd1;
    localparam logic [2:0] WB_MEM = 3'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/dmem_lsu_load_extend.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends
// it according to funct3; word loads pass straight through.
module dmem_lsu_load_extend
    import dmem_lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_ext
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_funct3)
            F3_B:    o_ext = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_ext = {{16{w_half[15]}}, w_half};
            F3_BU:   o_ext = {24'd0, w_byte};
            F3_HU:   o_ext = {16'd0, w_half};
            default: o_ext = i_rdata;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit: issues one access at a time on a valid/grant/rvalid
// data bus, aligns store lanes, extends load data and stalls until done.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_mem_wr_en,
    input  logic [2:0]        i_reg_write_ctrl,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_stall,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_ld_valid,
    output logic              o_acc_err,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [3:0]        o_dmem_be,
    output logic [DATA_W-1:0] o_dmem_wdata,
    input  logic              i_dmem_gnt,
    input  logic              i_dmem_rvalid,
    input  logic [DATA_W-1:0] i_dmem_rdata
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("dmem_lsu: DATA_W must be 32");
    end

    lsu_state_t        r_state;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_ld_valid;
    logic [1:0]        r_off;
    logic [2:0]        r_f3;

    logic              w_is_st;
    logic              w_is_ld;
    logic              w_f3_ok;
    logic              w_aligned;
    logic              w_legal;
    logic              w_idle;
    logic [3:0]        w_be_st;
    logic [DATA_W-1:0] w_wdata_st;
    logic [DATA_W-1:0] w_ext;

    assign w_is_st = i_mem_wr_en;
    assign w_is_ld = (i_reg_write_ctrl == WB_MEM) & ~i_mem_wr_en;
    assign w_idle  = (r_state == S_IDLE);

    always_comb begin
        case (i_funct3)
            F3_B, F3_H, F3_W: w_f3_ok = 1'b1;
            F3_BU, F3_HU:     w_f3_ok = w_is_ld;
            default:          w_f3_ok = 1'b0;
        endcase
        // funct3[0] marks a half access, funct3[1] a word access
        if (i_funct3[0])
            w_aligned = ~i_addr[0];
        else if (i_funct3[1])
            w_aligned = (i_addr[1:0] == 2'b00);
        else
            w_aligned = 1'b1;
    end

    assign w_legal = (w_is_st | w_is_ld) & w_f3_ok & w_aligned;

    always_comb begin
        w_be_st    = 4'b1111;
        w_wdata_st = i_wr_data;
        case (i_funct3[1:0])
            2'b00: begin
                w_be_st    = 4'b0001 << i_addr[1:0];
                w_wdata_st = {4{i_wr_data[7:0]}};
            end
            2'b01: begin
                w_be_st    = i_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_st = {2{i_wr_data[15:0]}};
            end
            default: ;
        endcase
    end

    dmem_lsu_load_extend u_load_extend (
        .i_rdata  (i_dmem_rdata),
        .i_offset (r_off),
        .i_funct3 (r_f3),
        .o_ext    (w_ext)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_be       <= 4'b0000;
            r_wdata    <= '0;
            r_rd_data  <= '0;
            r_ld_valid <= 1'b0;
            r_off      <= 2'b00;
            r_f3       <= 3'b000;
        end else begin
            r_ld_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_legal) begin
                        r_req   <= 1'b1;
                        r_we    <= w_is_st;
                        r_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
                        r_be    <= w_is_st ? w_be_st : 4'b1111;
                        r_wdata <= w_is_st ? w_wdata_st : '0;
                        r_off   <= i_addr[1:0];
                        r_f3    <= i_funct3;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_dmem_gnt) begin
                        r_req   <= 1'b0;
                        r_state <= r_we ? S_IDLE : S_RESP;
                    end
                end
                S_RESP: begin
                    if (i_dmem_rvalid) begin
                        r_rd_data  <= w_ext;
                        r_ld_valid <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_stall = (w_idle & w_legal)
                   | ((r_state == S_REQ) & ~(r_we & i_dmem_gnt))
                   | ((r_state == S_RESP) & ~i_dmem_rvalid);
    assign o_acc_err    = w_idle & (w_is_st | w_is_ld) & ~w_legal;
    assign o_rd_data    = r_rd_data;
    assign o_ld_valid   = r_ld_valid;
    assign o_dmem_req   = r_req;
    assign o_dmem_we    = r_we;
    assign o_dmem_addr  = r_addr;
    assign o_dmem_be    = r_be;
    assign o_dmem_wdata = r_wdata;

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized and directed checks of dmem_lsu against a byte-lane reference model.
module tb_dmem_lsu;

    logic        clk;
    logic        reset;
    logic        mem_wr_en;
    logic [2:0]  reg_write_ctrl;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        stall;
    logic [31:0] rd_data;
    logic        ld_valid;
    logic        acc_err;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] m_rd = 32'd0;

    dmem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_mem_wr_en      (mem_wr_en),
        .i_reg_write_ctrl (reg_write_ctrl),
        .i_funct3         (funct3),
        .i_addr           (addr),
        .i_wr_data        (wr_data),
        .o_stall          (stall),
        .o_rd_data        (rd_data),
        .o_ld_valid       (ld_valid),
        .o_acc_err        (acc_err),
        .o_dmem_req       (dmem_req),
        .o_dmem_we        (dmem_we),
        .o_dmem_addr      (dmem_addr),
        .o_dmem_be        (dmem_be),
        .o_dmem_wdata     (dmem_wdata),
        .i_dmem_gnt       (dmem_gnt),
        .i_dmem_rvalid    (dmem_rvalid),
        .i_dmem_rdata     (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_size(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit m_legal(input bit st, input bit ld, input logic [2:0] f3, input logic [31:0] a);
        bit ok;
        if (st)      ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        else if (ld) ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        else         ok = 0;
        return ok && ((a % m_size(f3)) == 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = m_size(f3);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = m_size(f3);
        r = 32'd0;
        for (int lane = 0; lane < 4; lane++)
            r = r | (((wd >> (8 * (lane % n))) & 32'hFF) << (8 * lane));
        return r;
    endfunction

    function automatic logic [31:0] m_ext(input logic [31:0] rdat, input int off, input logic [2:0] f3);
        logic [31:0] v;
        logic [31:0] mask;
        int n;
        n = m_size(f3);
        if (n == 4) return rdat;
        mask = (32'd1 << (8 * n)) - 32'd1;
        v = (rdat >> (8 * off)) & mask;
        if (!f3[2] && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic idle_inputs();
        mem_wr_en      = 1'b0;
        reg_write_ctrl = 3'd0;
        funct3         = 3'd0;
        dmem_gnt       = 1'b0;
        dmem_rvalid    = 1'b0;
    endtask

    task automatic do_op(input bit st, input logic [2:0] ctrl, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input int gdly,
                         input int rdly, input logic [31:0] rdat, input bit noise);
        bit is_ld;
        bit legal;
        bit g;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        is_ld = (ctrl == 3'd2) && !st;
        legal = m_legal(st, is_ld, f3, a);
        e_be  = st ? m_be(f3, a) : 4'b1111;
        e_wd  = st ? m_wdata(f3, wd) : 32'd0;

        @(posedge clk); #1;
        mem_wr_en = st; reg_write_ctrl = ctrl; funct3 = f3; addr = a; wr_data = wd;
        dmem_gnt = 1'b0; dmem_rvalid = noise; dmem_rdata = $urandom;
        @(negedge clk);
        chk("stall_c0", {31'd0, stall}, {31'd0, legal});
        chk("acc_err_c0", {31'd0, acc_err}, {31'd0, (st || is_ld) && !legal});
        chk("req_c0", {31'd0, dmem_req}, 32'd0);
        chk("ld_valid_c0", {31'd0, ld_valid}, 32'd0);

        @(posedge clk); #1;
        mem_wr_en = 1'b0; reg_write_ctrl = 3'd0; dmem_rvalid = 1'b0;
        if (!legal) begin
            @(negedge clk);
            chk("req_noacc", {31'd0, dmem_req}, 32'd0);
            chk("rd_hold", rd_data, m_rd);
            chk("ld_valid_noacc", {31'd0, ld_valid}, 32'd0);
            return;
        end

        for (int k = 0; k <= gdly; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            g = (k == gdly);
            dmem_gnt = g;
            dmem_rvalid = noise && ($urandom_range(0, 1) == 1);
            dmem_rdata = $urandom;
            @(negedge clk);
            chk("req_hold", {31'd0, dmem_req}, 32'd1);
            chk("we", {31'd0, dmem_we}, {31'd0, st});
            chk("addr", dmem_addr, a & 32'hFFFF_FFFC);
            chk("be", {28'd0, dmem_be}, {28'd0, e_be});
            chk("wdata", dmem_wdata, e_wd);
            chk("stall_req", {31'd0, stall}, {31'd0, st ? !g : 1'b1});
        end
        @(posedge clk); #1;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;

        if (st) begin
            @(negedge clk);
            chk("req_after_st", {31'd0, dmem_req}, 32'd0);
            chk("stall_after_st", {31'd0, stall}, 32'd0);
            return;
        end

        for (int j = 1; j <= rdly; j++) begin
            if (j > 1) begin @(posedge clk); #1; end
            dmem_rvalid = (j == rdly);
            dmem_rdata = (j == rdly) ? rdat : $urandom;
            @(negedge clk);
            chk("req_resp", {31'd0, dmem_req}, 32'd0);
            chk("stall_resp", {31'd0, stall}, {31'd0, j != rdly});
        end
        @(posedge clk); #1;
        dmem_rvalid = 1'b0; dmem_rdata = $urandom;
        m_rd = m_ext(rdat, int'(a % 4), f3);
        @(negedge clk);
        chk("ld_valid", {31'd0, ld_valid}, 32'd1);
        chk("rd_data", rd_data, m_rd);
        chk("stall_done", {31'd0, stall}, 32'd0);
    endtask

    initial begin
        bit          st;
        logic [2:0]  ctrl;
        logic [2:0]  f3;
        logic [31:0] a;
        int          sel;

        idle_inputs();
        addr = 32'd0; wr_data = 32'd0; dmem_rdata = 32'd0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_be", {28'd0, dmem_be}, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_rd", rd_data, 32'd0);
        chk("rst_ldv", {31'd0, ld_valid}, 32'd0);

        // directed accesses
        do_op(1'b1, 3'd0, 3'b000, 32'h1003, 32'h0000_00AB, 0, 1, 32'd0, 1'b0);
        do_op(1'b0, 3'd2, 3'b001, 32'h2002, 32'd0, 0, 1, 32'h8001_1234, 1'b0);
        do_op(1'b0, 3'd2, 3'b100, 32'h3001, 32'd0, 0, 1, 32'h0000_F000, 1'b0);
        do_op(1'b0, 3'd2, 3'b000, 32'h3001, 32'd0, 0, 1, 32'h0000_F000, 1'b0);
        do_op(1'b0, 3'd2, 3'b010, 32'h2001, 32'd0, 0, 1, 32'd0, 1'b0);
        do_op(1'b0, 3'd2, 3'b011, 32'h2000, 32'd0, 0, 1, 32'd0, 1'b0);
        do_op(1'b1, 3'd0, 3'b010, 32'h0040, 32'hDEAD_BEEF, 3, 1, 32'd0, 1'b0);
        do_op(1'b1, 3'd2, 3'b001, 32'h0052, 32'h1234_5678, 1, 1, 32'd0, 1'b0);

        // reset while waiting for read data; the late rvalid must be dropped
        @(posedge clk); #1;
        mem_wr_en = 1'b0; reg_write_ctrl = 3'd2; funct3 = 3'b010; addr = 32'h100;
        @(negedge clk);
        chk("mr_stall_c0", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        reg_write_ctrl = 3'd0; dmem_gnt = 1'b1;
        @(negedge clk);
        chk("mr_req", {31'd0, dmem_req}, 32'd1);
        @(posedge clk); #1;
        dmem_gnt = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("mr_stall_resp", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("mr_req_off", {31'd0, dmem_req}, 32'd0);
        chk("mr_stall_off", {31'd0, stall}, 32'd0);
        chk("mr_ldv0", {31'd0, ld_valid}, 32'd0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        chk("mr_ldv1", {31'd0, ld_valid}, 32'd0);
        chk("mr_rd", rd_data, 32'd0);
        m_rd = 32'd0;

        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            st = (sel < 4) || (sel == 9);
            ctrl = (sel >= 4) ? 3'd2 : 3'($urandom_range(0, 7));
            if (sel == 8) ctrl = 3'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                             : 3'($urandom_range(0, 2)) | (st ? 3'd0 : 3'($urandom_range(0, 1) * 4));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(m_size(f3)) - 32'd1);
            do_op(st, ctrl, f3, a, $urandom, $urandom_range(0, 3), $urandom_range(1, 3),
                  $urandom, 1'($urandom_range(0, 1)));
        end

        idle_inputs();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
